// File: rtl/my_fsm_pkg.sv
// Shared constants for the 1011 serial pattern detector: state encoding and pattern.
package my_fsm_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned PATTERN_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_1     = 3'd1,
        S_10    = 3'd2,
        S_101   = 3'd3,
        S_MATCH = 3'd4
    } state_t;

    // First-received bit is the MSB.
    localparam logic [PATTERN_W-1:0] PATTERN = 4'b1011;

endpackage

// File: rtl/my_fsm_unit.sv
// Moore detector for the serial pattern 1011; out pulses one cycle per match.
// MY_FSM_OVERLAP_EN selects overlapping detection (default build: non-overlapping).
module my_fsm_unit
    import my_fsm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
);

    state_t state;
    state_t state_nxt;

    // State register; reset wins over any value on in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: each progress state advances when in matches the next pattern bit.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = (in == PATTERN[3]) ? S_1     : S_IDLE;
            S_1:     state_nxt = (in == PATTERN[2]) ? S_10    : S_1;
            S_10:    state_nxt = (in == PATTERN[1]) ? S_101   : S_IDLE;
            S_101:   state_nxt = (in == PATTERN[0]) ? S_MATCH : S_10;
`ifdef MY_FSM_OVERLAP_EN
            S_MATCH: state_nxt = in ? S_1 : S_10;
`else
            S_MATCH: state_nxt = in ? S_1 : S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out = (state == S_MATCH);

endmodule

// File: tb/tb_my_fsm_unit.sv
// Scoreboard bench for my_fsm_unit: driver queues expected out per edge, monitor checks after each edge.
module tb_my_fsm_unit;
    import my_fsm_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic out;

    int compared   = 0;
    int mismatched = 0;

    bit    exp_q[$];
    string name_q[$];

    my_fsm_unit dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    always #5 clock = ~clock;

    // Monitor: one expected value per edge, sampled just after the edge.
    initial begin
        bit    e;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                compared++;
                if (out !== e) begin
                    mismatched++;
                    $display("FAIL %s: out=%b expected=%b", nm, out, e);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic b, input bit e, input string nm);
        @(negedge clock);
        reset = r;
        in    = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Feed n bits (first bit is bits[n-1]) with expected out after each edge.
    task automatic run_seq(input string nm, input logic [31:0] bits,
                           input logic [31:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b0, bits[i], exp[i], $sformatf("%s_bit%0d", nm, n - i));
        end
    endtask

    task automatic do_reset(input string nm);
        drive(1'b1, 1'b0, 1'b0, nm);
    endtask

    task automatic check_idle(input string nm);
        @(posedge clock);
        #2;
        compared++;
        if (dut.state !== S_IDLE) begin
            mismatched++;
            $display("FAIL %s: state=%0d expected=%0d", nm, dut.state, S_IDLE);
        end
    endtask

    initial begin
        int budget;

        do_reset("reset0");
        check_idle("reset0_state");

        run_seq("smoke", 32'b0100, 32'b0000, 4);

        do_reset("reset1");
        run_seq("match", 32'b10110, 32'b00010, 5);

        do_reset("reset2");
`ifdef MY_FSM_OVERLAP_EN
        run_seq("overlap", 32'b1011011, 32'b0001001, 7);
`else
        run_seq("overlap", 32'b1011011, 32'b0001000, 7);
`endif

        do_reset("reset3");
        run_seq("near1", 32'b11011, 32'b00001, 5);

        do_reset("reset4");
        run_seq("near2", 32'b1001011, 32'b0000001, 7);

        // Reset after 101 with in=1: would otherwise complete the pattern.
        do_reset("reset5");
        run_seq("mid", 32'b101, 32'b000, 3);
        drive(1'b1, 1'b1, 1'b0, "mid_reset");
        check_idle("mid_reset_state");
        run_seq("post_reset", 32'b1, 32'b0, 1);

        // Reset with unknown data still lands in idle.
        drive(1'b1, 1'bx, 1'b0, "reset_x");
        check_idle("reset_x_state");

        run_seq("ones", 32'hFFFF, 32'h0000, 16);
        do_reset("reset6");
        run_seq("zeros", 32'h0000, 32'h0000, 16);

        // Back-to-back match then ones: pulse must be one cycle wide.
        do_reset("reset7");
        run_seq("width", 32'b101111, 32'b000100, 6);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #3;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
